// File: rtl/bus_bank_pkg.sv
// Shared constants and helpers for the bus register bank: default sizing,
// pattern source reset value, pattern-source index rule and driver popcount.
package bus_bank_pkg;

  localparam int          DEF_WIDTH        = 16;
  localparam int          DEF_NUM_REGS     = 10;
  localparam int          DEF_CNT_W        = 8;
  localparam logic [15:0] DEF_PATTERN_INIT = 16'h5500;
  // Up to 32 registers plus the pattern source.
  localparam int          MAX_DRV          = 33;

  // The pattern source always sits one past the last register index.
  function automatic int src_ext(input int num_regs);
    return num_regs;
  endfunction

  function automatic logic [5:0] popcount(input logic [MAX_DRV-1:0] v);
    logic [5:0] n;
    n = '0;
    for (int i = 0; i < MAX_DRV; i++) n = n + {5'b0, v[i]};
    return n;
  endfunction

endpackage

// File: rtl/bus_source_mux.sv
// Checked one-hot bus source mux: selects the sole active driver, otherwise
// drives zero and reports whether the bus is idle or contended.
module bus_source_mux
  import bus_bank_pkg::*;
#(
  parameter  int WIDTH    = DEF_WIDTH,
  parameter  int NUM_REGS = DEF_NUM_REGS,
  localparam int SRC_W    = $clog2(NUM_REGS + 1)
) (
  input  logic [NUM_REGS:0]               drv,
  input  logic [NUM_REGS-1:0][WIDTH-1:0]  regs,
  input  logic [WIDTH-1:0]                pattern,
  output logic [WIDTH-1:0]                bus_out,
  output logic                            bus_valid,
  output logic [SRC_W-1:0]                src,
  output logic                            multi
);

  logic [5:0]       n;
  logic [WIDTH-1:0] sel;

  // OR of masked sources; only trusted when exactly one driver is active.
  always_comb begin
    n   = popcount(MAX_DRV'(drv));
    sel = drv[NUM_REGS] ? pattern : '0;
    src = drv[NUM_REGS] ? SRC_W'(src_ext(NUM_REGS)) : '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (drv[i]) begin
        sel = sel | regs[i];
        src = SRC_W'(i);
      end
    end
    bus_valid = (n == 6'd1);
    multi     = (n > 6'd1);
    bus_out   = bus_valid ? sel : '0;
  end

endmodule

// File: rtl/bus_register_bank.sv
// Register bank on a shared internal bus with pattern source, contention flag
// and transfer counter. Define BUS_REGISTER_BANK_SNOOP_EN for last_bus/last_src.
module bus_register_bank
  import bus_bank_pkg::*;
#(
  parameter  int               WIDTH        = DEF_WIDTH,
  parameter  int               NUM_REGS     = DEF_NUM_REGS,
  parameter  logic [WIDTH-1:0] PATTERN_INIT = WIDTH'(DEF_PATTERN_INIT),
  parameter  int               CNT_W        = DEF_CNT_W,
  localparam int               SRC_W        = $clog2(NUM_REGS + 1)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      step,
  input  logic                      ext_drive,
  input  logic [NUM_REGS-1:0]       enable,
  input  logic [NUM_REGS-1:0]       latch,
  output logic [WIDTH-1:0]          bus_out,
  output logic [NUM_REGS*WIDTH-1:0] reg_out,
  output logic                      bus_valid,
  output logic                      contention,
  output logic [CNT_W-1:0]          xfer_count
`ifdef BUS_REGISTER_BANK_SNOOP_EN
  ,
  output logic [WIDTH-1:0]          last_bus,
  output logic [SRC_W-1:0]          last_src
`endif
);

  logic [NUM_REGS-1:0][WIDTH-1:0] regs;
  logic [WIDTH-1:0]               pattern;
  logic [SRC_W-1:0]               src;
  logic                           multi;
  logic                           xfer;
  logic                           pat_sel;

  bus_source_mux #(.WIDTH(WIDTH), .NUM_REGS(NUM_REGS)) u_mux (
    .drv       ({ext_drive, enable}),
    .regs      (regs),
    .pattern   (pattern),
    .bus_out   (bus_out),
    .bus_valid (bus_valid),
    .src       (src),
    .multi     (multi)
  );

  assign xfer    = step & bus_valid & (|latch);
  assign pat_sel = bus_valid & (src == SRC_W'(src_ext(NUM_REGS)));
  assign reg_out = regs;

  always_ff @(posedge clk) begin
    if (!reset) begin
      regs       <= '0;
      pattern    <= PATTERN_INIT;
      contention <= 1'b0;
      xfer_count <= '0;
    end else if (step) begin
      // Broadcast capture; a self-transfer simply reloads the same value.
      for (int i = 0; i < NUM_REGS; i++)
        if (latch[i] && bus_valid) regs[i] <= bus_out;
      if (pat_sel) pattern <= pattern + WIDTH'(1);
      if (multi) contention <= 1'b1;
      if (xfer && xfer_count != '1) xfer_count <= xfer_count + CNT_W'(1);
    end
  end

`ifdef BUS_REGISTER_BANK_SNOOP_EN
  always_ff @(posedge clk) begin
    if (!reset) begin
      last_bus <= '0;
      last_src <= '0;
    end else if (xfer) begin
      last_bus <= bus_out;
      last_src <= src;
    end
  end
`endif

endmodule

// File: tb/tb_bus_register_bank.sv
// Randomized scoreboard bench for bus_register_bank against an array-based
// reference model; snoop ports are covered when BUS_REGISTER_BANK_SNOOP_EN is set.
module tb_bus_register_bank;

  localparam int          W  = 16;
  localparam int          N  = 10;
  localparam int          CW = 3;
  localparam int          SW = 4;
  localparam logic [W-1:0] PI = 16'hFFFE;

  logic           clk = 1'b0;
  logic           reset, step, ext_drive;
  logic [N-1:0]   enable, latch;
  logic [W-1:0]   bus_out;
  logic [N*W-1:0] reg_out;
  logic           bus_valid, contention;
  logic [CW-1:0]  xfer_count;
`ifdef BUS_REGISTER_BANK_SNOOP_EN
  logic [W-1:0]   last_bus;
  logic [SW-1:0]  last_src;
`endif

  bus_register_bank #(.WIDTH(W), .NUM_REGS(N), .PATTERN_INIT(PI), .CNT_W(CW)) dut (
    .clk        (clk),
    .reset      (reset),
    .step       (step),
    .ext_drive  (ext_drive),
    .enable     (enable),
    .latch      (latch),
    .bus_out    (bus_out),
    .reg_out    (reg_out),
    .bus_valid  (bus_valid),
    .contention (contention),
    .xfer_count (xfer_count)
`ifdef BUS_REGISTER_BANK_SNOOP_EN
    ,
    .last_bus   (last_bus),
    .last_src   (last_src)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0]   bus;
    logic           valid;
    logic [N*W-1:0] regs;
    logic           cont;
    logic [CW-1:0]  cnt;
    logic [W-1:0]   lb;
    logic [SW-1:0]  ls;
  } exp_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;

  // Reference model state
  logic [W-1:0] m_reg[N];
  logic [W-1:0] m_pat;
  bit           m_cont;
  int           m_cnt;
  logic [W-1:0] m_lb;
  int           m_ls;

  task automatic chk(input string nm, input logic [N*W-1:0] got, input logic [N*W-1:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, got, want);
    end
  endtask

  task automatic cyc(input bit rst_n, input bit st, input bit ex,
                     input logic [N-1:0] en, input logic [N-1:0] la);
    exp_t         e;
    int           nd;
    int           srcv;
    logic [W-1:0] v;
    @(negedge clk);
    reset = rst_n; step = st; ext_drive = ex; enable = en; latch = la;
    nd   = $countones(en) + (ex ? 1 : 0);
    v    = '0;
    srcv = 0;
    if (nd == 1) begin
      if (ex) begin
        v = m_pat; srcv = N;
      end else begin
        for (int i = 0; i < N; i++) if (en[i]) begin v = m_reg[i]; srcv = i; end
      end
    end
    e.bus   = v;
    e.valid = (nd == 1);
    if (!rst_n) begin
      for (int i = 0; i < N; i++) m_reg[i] = '0;
      m_pat = PI; m_cont = 0; m_cnt = 0; m_lb = '0; m_ls = 0;
    end else if (st) begin
      if (nd > 1) m_cont = 1;
      if (nd == 1) begin
        for (int i = 0; i < N; i++) if (la[i]) m_reg[i] = v;
        if (ex) m_pat = m_pat + 1;
        if (la != '0) begin
          if (m_cnt < (1 << CW) - 1) m_cnt++;
          m_lb = v; m_ls = srcv;
        end
      end
    end
    for (int i = 0; i < N; i++) e.regs[i*W +: W] = m_reg[i];
    e.cont = m_cont;
    e.cnt  = CW'(m_cnt);
    e.lb   = m_lb;
    e.ls   = SW'(m_ls);
    q.push_back(e);
  endtask

  // Monitor: combinational outputs mid-low-phase, state just after the edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("bus_out", N*W'(bus_out), N*W'(e.bus));
        chk("bus_valid", N*W'(bus_valid), N*W'(e.valid));
        @(posedge clk);
        #1;
        chk("reg_out", reg_out, e.regs);
        chk("contention", N*W'(contention), N*W'(e.cont));
        chk("xfer_count", N*W'(xfer_count), N*W'(e.cnt));
`ifdef BUS_REGISTER_BANK_SNOOP_EN
        chk("last_bus", N*W'(last_bus), N*W'(e.lb));
        chk("last_src", N*W'(last_src), N*W'(e.ls));
`endif
      end
    end
  end

  initial begin
    logic [N-1:0] en, la;
    int           mode, a, b;
    reset = 1'b0; step = 1'b0; ext_drive = 1'b0; enable = '0; latch = '0;
    cyc(0, 0, 0, '0, '0);
    cyc(0, 1, 0, '0, '0);
    // Directed: pattern wrap, broadcast, contention, idle step, self-transfer
    cyc(1, 1, 1, '0, 10'b0000000001);
    cyc(1, 1, 1, '0, 10'b0000000001);
    cyc(1, 1, 1, '0, 10'b0000000010);
    cyc(1, 1, 0, 10'b0000000001, 10'b0000101000);
    cyc(1, 1, 0, 10'b0000000110, 10'b0000010000);
    cyc(1, 1, 0, 10'b0000001000, 10'b0000010000);
    cyc(1, 0, 1, '0, 10'b0000000001);
    cyc(1, 1, 0, 10'b0000001000, 10'b0000001000);
    cyc(1, 1, 1, '0, '0);
    cyc(1, 1, 0, 10'b0000000001, 10'b0000000100);
    cyc(1, 1, 1, '0, 10'b1000000000);
    cyc(0, 1, 1, '0, 10'b0000000001);
    cyc(1, 1, 0, 10'b0000000001, 10'b0000000010);
    // Random traffic
    for (int k = 0; k < 600; k++) begin
      mode = int'($urandom_range(0, 9));
      en   = '0;
      a    = int'($urandom_range(0, N-1));
      b    = (a + 1 + int'($urandom_range(0, N-2))) % N;
      if (mode >= 2 && mode <= 5) en[a] = 1'b1;
      if (mode == 8) begin en[a] = 1'b1; en[b] = 1'b1; end
      if (mode == 9) en[a] = 1'b1;
      la = ($urandom_range(0, 2) == 0) ? '0 : N'($urandom & $urandom);
      cyc($urandom_range(0, 24) != 0, $urandom_range(0, 3) != 0,
          (mode == 6 || mode == 7 || mode == 9), en, la);
    end
    for (int k = 0; k < 20 && q.size() > 0; k++) @(posedge clk);
    repeat (2) @(posedge clk);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/bus_register_bank.md
Name: bus_register_bank

Overview:
- Parametrised bank of NUM_REGS general registers sharing one internal WIDTH-bit datapath bus.
- Replaces the per-register tri-state bus with a checked one-hot source mux.
- Adds an auto-incrementing external pattern source, contention detection and a transfer counter.
- Sits between the single-step clock pulse logic and the datapath/LED debug outputs; all state advances only on qualified steps.

Parameters:
- WIDTH, 16, bit width of each register and of the bus.
- NUM_REGS, 10, number of bank registers (GPR, MDR, IR, timer, conrom, MAR, Y, Z, PSW, spare); legal range 1..32.
- PATTERN_INIT, 16'h5500, reset value of the external pattern source, truncated/zero-extended to WIDTH.
- CNT_W, 8, width of the transfer counter.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-low reset.
- step  in  1  one-cycle update qualifier (one-shot pulse); no state changes when low, except reset.
- ext_drive  in  1  pattern source requests the bus.
- enable  in  NUM_REGS  per-register request to drive the bus (one-hot expected).
- latch  in  NUM_REGS  per-register capture-from-bus strobe.
- bus_out  out  WIDTH  current bus value (combinational).
- reg_out  out  NUM_REGS*WIDTH  flattened register contents; register i occupies bits [i*WIDTH +: WIDTH].
- bus_valid  out  1  exactly one driver active (combinational).
- contention  out  1  sticky error flag.
- xfer_count  out  CNT_W  saturating count of completed transfers.

Behaviour:
- Driver vector = {ext_drive, enable}; drivers = popcount of that vector.
  - drivers==0: bus_out=0, bus_valid=0.
  - drivers==1: bus_out = the selected register or the pattern register; bus_valid=1.
  - drivers>=2: bus_out=0, bus_valid=0.
- Register i load condition: reset high & step & latch[i] & bus_valid. Load takes effect at the clock edge, i.e. visible on reg_out the next cycle.
- Multiple latch bits may be set in the same step; all selected registers load the same value (broadcast).
- Self-transfer (enable[i] & latch[i], sole driver): register i reloads its own value, which is a legal no-op.
- Latches are ignored when bus_valid=0; registers hold.
- Pattern register:
  - Increments by 1 (modulo 2^WIDTH, so 0xFFFF wraps to 0x0000) on step when ext_drive is the sole driver.
  - Increments whether or not any latch is set.
  - The incremented value is the one driven on the next drive.
- contention: set on step when drivers>=2; cleared only by reset.
- xfer_count: +1 on step when bus_valid & |latch; saturates at 2^CNT_W-1, with no wrap.
- Reset (reset==0 at posedge, regardless of step):
  - all registers = 0
  - pattern = PATTERN_INIT
  - contention = 0
  - xfer_count = 0
  - snoop outputs (if present) = 0
- Reset dominates every simultaneous event. Reset asserted mid-sequence discards that cycle's transfer.
- Combinational outputs (bus_out, bus_valid) follow the inputs during reset. Captures are blocked during reset.

Optional Feature:
- Macro: BUS_REGISTER_BANK_SNOOP_EN.
- When defined, two extra outputs are added:
  - last_bus (WIDTH): value of the most recent valid transfer.
  - last_src ($clog2(NUM_REGS+1) bits): index of its source; the value NUM_REGS means the pattern source.
- Both update on the same step condition as xfer_count (ignoring saturation); reset value 0.
- When undefined, these ports and their registers do not exist, and all other behaviour is identical.

Decomposition:
- Package bus_bank_pkg holds:
  - default WIDTH/NUM_REGS/CNT_W constants
  - the PATTERN_INIT default
  - the SRC_EXT encoding rule (index NUM_REGS)
  - a popcount function used for driver counting
- One natural sub-module: bus_source_mux. It is purely combinational and takes the driver vector and register/pattern values; it outputs bus_out, bus_valid, the driver index and the multi-driver indication. The bank instantiates it once and keeps all sequential state itself.

Test Plan:
- Reset then ext_drive=1, latch[0]=1, step -> reg0=0x5500, pattern=0x5501, xfer_count=1, contention=0.
- enable[0]=1, latch[3]=1, latch[5]=1, step -> reg3=reg5=0x5500, reg0 unchanged, xfer_count=2, pattern unchanged.
- enable[1]=1, enable[2]=1, latch[4]=1, step -> bus_out=0, bus_valid=0, reg4 unchanged, contention=1. A later valid step leaves contention=1 until reset.
- Preload pattern to 0xFFFF via reset with PATTERN_INIT=16'hFFFF; ext_drive with latch[0] on two steps -> reg0=0xFFFF then 0x0000.
- CNT_W=2: five valid transfers -> xfer_count reads 1,2,3,3,3.
- Valid transfer with reset=0 and step=1 in the same cycle -> all registers 0, pattern=PATTERN_INIT, xfer_count=0. Inputs with step=0 -> no state change.
